// File: rtl/tournament_br_pred.sv
// Tournament branch predictor: a gshare global predictor and a per-PC local
// history predictor, arbitrated per branch by a meta chooser table.
// Predictions are made combinationally at fetch, carried down a record pipe
// that tracks the CPU pipeline, and resolved at the mem stage.
// Optional feature macro: BR_PRED_STATS_EN adds resolved-branch and
// mispredict counters on stat_branches / stat_mispred.
//
// Handshake: read qualifies pc_in (a branch is being fetched); load qualifies
// br_taken / pc_mem_stage (a resolved branch sits in mem). Neither side has
// backpressure; stall freezes the record pipe and every table update while
// pred_taken and flush stay combinational.
module tournament_br_pred #(
    parameter int GHR_LEN    = 8,
    parameter int LHT_IDX    = 6,
    parameter int LHIST_LEN  = 8,
    parameter int META_IDX   = 8,
    parameter int CTR_W      = 2,
    parameter int PIPE_DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        load,
    input  logic        br_taken,
    input  logic [31:0] pc_mem_stage,
    output logic        pred_taken,
    output logic        flush,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
);
    localparam int G_ENTRIES = 1 << GHR_LEN;
    localparam int L_ENTRIES = 1 << LHIST_LEN;
    localparam int H_ENTRIES = 1 << LHT_IDX;
    localparam int M_ENTRIES = 1 << META_IDX;
    localparam int TAIL      = PIPE_DEPTH - 1;

    // Weak state: MSB clear, all lower bits set (weakly not-taken / weakly global).
    localparam logic [CTR_W-1:0] CTR_WEAK = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    // Saturating step of a counter toward "up" (increment) or down.
    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
        if (up) begin
            return (c == CTR_MAX) ? c : c + CTR_ONE;
        end
        return (c == '0) ? c : c - CTR_ONE;
    endfunction

    // Prediction tables and histories.
    logic [CTR_W-1:0]     r_gpht [G_ENTRIES];
    logic [CTR_W-1:0]     r_lpht [L_ENTRIES];
    logic [CTR_W-1:0]     r_meta [M_ENTRIES];
    logic [LHIST_LEN-1:0] r_lht  [H_ENTRIES];
    logic [GHR_LEN-1:0]   r_ghr;

    // Record pipe, one entry per stage; index TAIL lines up with mem.
    logic                 r_valid [PIPE_DEPTH];
    logic [31:0]          r_pc    [PIPE_DEPTH];
    logic                 r_pred  [PIPE_DEPTH];
    logic                 r_gp    [PIPE_DEPTH];
    logic                 r_lp    [PIPE_DEPTH];
    logic [GHR_LEN-1:0]   r_gidx  [PIPE_DEPTH];
    logic [LHIST_LEN-1:0] r_lidx  [PIPE_DEPTH];
    logic [META_IDX-1:0]  r_midx  [PIPE_DEPTH];

    // Fetch-side lookup (reads current state, so an update in the same cycle is not seen).
    logic [GHR_LEN-1:0]   w_g_idx;
    logic [LHT_IDX-1:0]   w_lht_rd;
    logic [LHIST_LEN-1:0] w_l_idx;
    logic [META_IDX-1:0]  w_m_idx;
    logic                 w_g_pred;
    logic                 w_l_pred;
    logic                 w_pred;

    assign w_g_idx  = r_ghr ^ pc_in[GHR_LEN+1:2];
    assign w_lht_rd = pc_in[LHT_IDX+1:2];
    assign w_l_idx  = r_lht[w_lht_rd];
    assign w_m_idx  = pc_in[META_IDX+1:2];
    assign w_g_pred = r_gpht[w_g_idx][CTR_W-1];
    assign w_l_pred = r_lpht[w_l_idx][CTR_W-1];
    assign w_pred   = r_meta[w_m_idx][CTR_W-1] ? w_l_pred : w_g_pred;

    // Mem-side resolve against the oldest record.
    logic               w_hit;
    logic               w_flush;
    logic               w_update;
    logic [LHT_IDX-1:0] w_lht_wr;

    assign w_hit    = load && r_valid[TAIL] && (r_pc[TAIL] == pc_mem_stage);
    assign w_flush  = w_hit && (r_pred[TAIL] != br_taken);
    assign w_update = w_hit && !stall;
    assign w_lht_wr = pc_mem_stage[LHT_IDX+1:2];

    assign pred_taken = w_pred;
    assign flush      = w_flush;

    // Record pipe: shift on !stall; a flush kills every younger (wrong-path) record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_pc[i]    <= '0;
                r_pred[i]  <= 1'b0;
                r_gp[i]    <= 1'b0;
                r_lp[i]    <= 1'b0;
                r_gidx[i]  <= '0;
                r_lidx[i]  <= '0;
                r_midx[i]  <= '0;
            end
        end else if (!stall) begin
            r_valid[0] <= read && !w_flush;
            r_pc[0]    <= pc_in;
            r_pred[0]  <= w_pred;
            r_gp[0]    <= w_g_pred;
            r_lp[0]    <= w_l_pred;
            r_gidx[0]  <= w_g_idx;
            r_lidx[0]  <= w_l_idx;
            r_midx[0]  <= w_m_idx;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1] && !w_flush;
                r_pc[i]    <= r_pc[i-1];
                r_pred[i]  <= r_pred[i-1];
                r_gp[i]    <= r_gp[i-1];
                r_lp[i]    <= r_lp[i-1];
                r_gidx[i]  <= r_gidx[i-1];
                r_lidx[i]  <= r_lidx[i-1];
                r_midx[i]  <= r_midx[i-1];
            end
        end
    end

    // Table training on a resolved hit, using the indices captured at fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
            for (int i = 0; i < G_ENTRIES; i++) r_gpht[i] <= CTR_WEAK;
            for (int i = 0; i < L_ENTRIES; i++) r_lpht[i] <= CTR_WEAK;
            for (int i = 0; i < M_ENTRIES; i++) r_meta[i] <= CTR_WEAK;
            for (int i = 0; i < H_ENTRIES; i++) r_lht[i]  <= '0;
        end else if (w_update) begin
            r_gpht[r_gidx[TAIL]] <= ctr_step(r_gpht[r_gidx[TAIL]], br_taken);
            r_lpht[r_lidx[TAIL]] <= ctr_step(r_lpht[r_lidx[TAIL]], br_taken);
            // Chooser moves only when the components disagreed; up means local was right.
            if (r_gp[TAIL] != r_lp[TAIL]) begin
                r_meta[r_midx[TAIL]] <= ctr_step(r_meta[r_midx[TAIL]], r_lp[TAIL] == br_taken);
            end
            r_ghr           <= {r_ghr[GHR_LEN-2:0], br_taken};
            r_lht[w_lht_wr] <= {r_lht[w_lht_wr][LHIST_LEN-2:0], br_taken};
        end
    end

`ifdef BR_PRED_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mis;

    // Resolved-branch and mispredict counters, free-running and wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else if (w_update) begin
            r_stat_br <= r_stat_br + 32'd1;
            if (w_flush) begin
                r_stat_mis <= r_stat_mis + 32'd1;
            end
        end
    end

    assign stat_branches = r_stat_br;
    assign stat_mispred  = r_stat_mis;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_tournament_br_pred.sv
// Directed bench for tournament_br_pred (default parameters, PIPE_DEPTH=3).
// Driver tasks queue the hand-computed pred_taken / flush for each cycle that
// presents read / load; a negedge monitor pops and compares.
module tb_tournament_br_pred;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read = 1'b0;
    logic [31:0] pc_in = '0;
    logic        stall = 1'b0;
    logic        load = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] pc_mem_stage = '0;
    logic        pred_taken;
    logic        flush;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected entries: {tag, value}; tag 0 = pred_taken, tag 1 = flush.
    logic [1:0] exp_q[$];

    tournament_br_pred dut (
        .clk           (clk),
        .rst           (rst),
        .read          (read),
        .pc_in         (pc_in),
        .stall         (stall),
        .load          (load),
        .br_taken      (br_taken),
        .pc_mem_stage  (pc_mem_stage),
        .pred_taken    (pred_taken),
        .flush         (flush),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic sb_pop(input logic tag, input logic act, input string name);
        logic [1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: output with no expected entry, got %0b (t=%0t)", name, act, $time);
        end else begin
            e = exp_q.pop_front();
            check(name, {30'd0, tag, act}, {30'd0, e});
        end
    endtask

    // Monitor: compare on every cycle that presents a fetch or a resolve.
    always @(negedge clk) begin
        if (read) sb_pop(1'b0, pred_taken, "pred_taken");
        if (load) sb_pop(1'b1, flush, "flush");
    end

    // One driven cycle; expectations queued for whichever of read/load is active.
    task automatic cyc(input logic rd, input logic [31:0] pc, input logic ld, input logic tk,
                       input logic [31:0] pcm, input logic st, input logic ep, input logic ef);
        @(posedge clk); #1;
        read = rd; pc_in = pc; load = ld; br_taken = tk; pc_mem_stage = pcm; stall = st;
        if (rd) exp_q.push_back({1'b0, ep});
        if (ld) exp_q.push_back({1'b1, ef});
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Fetch at pc, resolve PIPE_DEPTH cycles later with outcome tk.
    task automatic branch(input logic [31:0] pc, input logic tk, input logic ep);
        cyc(1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, ep, 1'b0);
        idle();
        idle();
        cyc(1'b0, 32'h0, 1'b1, tk, pc, 1'b0, 1'b0, ep ^ tk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; read = 1'b0; load = 1'b0; stall = 1'b0;
        br_taken = 1'b0; pc_in = '0; pc_mem_stage = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        do_reset();

        // Reset state: resolve with no record in flight -> no flush.
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);

        // First mispredict; simultaneous fetch of 0x104 sees pre-update GHR (idx 0x41).
        do_reset();
        cyc(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        cyc(1'b1, 32'h104, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        // GHR=01 now, 0x104 hits gPHT[0x40]=10 -> taken.
        cyc(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();

        // Always-taken 0x100: 9 cold indices while histories fill, then correct.
        do_reset();
        for (int i = 1; i <= 20; i++) branch(32'h100, 1'b1, (i >= 10));
        idle();
`ifdef BR_PRED_STATS_EN
        check("stat_branches", stat_branches, 32'd20);
        check("stat_mispred", stat_mispred, 32'd9);
`else
        check("stat_branches", stat_branches, 32'd0);
        check("stat_mispred", stat_mispred, 32'd0);
`endif

        // Always-not-taken: counters saturate at 0 without wrapping.
        do_reset();
        for (int i = 0; i < 5; i++) branch(32'h100, 1'b0, 1'b0);

        // Meta chooser: 0x308 disagreement trains meta[0xC2] toward local, then local wins.
        do_reset();
        branch(32'h304, 1'b1, 1'b0);
        branch(32'h308, 1'b1, 1'b0);
        branch(32'h308, 1'b0, 1'b0);

        // Stall with load held: flush follows the tail, no update until release.
        do_reset();
        cyc(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h104, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();

        // Flush with two younger records in flight: they are dropped.
        do_reset();
        cyc(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h404, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();

        // PC mismatch at mem: no flush, no training (0x304 would see gPHT[0xC0] otherwise).
        do_reset();
        cyc(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h304, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle();

        // Asynchronous reset mid-resolve: flush drops before any clock edge.
        do_reset();
        cyc(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        @(posedge clk); #1;
        read = 1'b0; load = 1'b1; br_taken = 1'b1; pc_mem_stage = 32'h100; stall = 1'b0;
        exp_q.push_back({1'b1, 1'b0});
        #1 rst = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
